mp_regfile: RTL and testbench
=============================

MP_REGFILE -- requirements
Module: mp_regfile

Interface
REQ-001 Parameter DW, default 32: data width in bits.
REQ-002 Parameter AW, default 5: address width in bits.
REQ-003 Parameter ENTRY, default 32: number of entries, 2 <= ENTRY <= 2^AW.
REQ-004 Parameter NRD, default 2: number of read ports, 1..4.
REQ-005 Parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding; 0 = no forwarding.
REQ-006 Parameter ZERO_R0, default 1: 1 = entry 0 is hardwired to zero.
REQ-007 CLK  input  1  single clock; all state changes on the rising edge.
REQ-008 RST  input  1  synchronous reset, active-high.
REQ-009 WEN0  input  1  write enable for port 0, active-low.
REQ-010 WA0  input  AW  write address for port 0.
REQ-011 DI0  input  DW  write data for port 0.
REQ-012 WEN1, WA1, DI1  input  1/AW/DW  write port 1, with the same meanings as port 0.
REQ-013 RA  input  NRD*AW  packed read addresses; port k occupies bits [k*AW +: AW].
REQ-014 DOUT  output  NRD*DW  packed read data; port k occupies bits [k*DW +: DW].
REQ-015 READY  output  1  high when the array is initialised and accepting writes.

Function
REQ-016 The block SHALL have a two-state FSM: CLEAR and RUN.
REQ-017 RST high at a rising edge SHALL force state CLEAR, clear counter 0 and READY 0.
REQ-018 In CLEAR, each cycle SHALL write zero to entry[counter] and then increment the counter.
REQ-019 CLEAR SHALL move to RUN on the edge that clears entry ENTRY-1; READY SHALL rise in the same edge.
REQ-020 With RST low, READY SHALL therefore be high exactly ENTRY cycles after RST falls.
REQ-021 Reasserting RST during CLEAR SHALL restart the clear from entry 0.
REQ-022 Writes presented while READY is low SHALL be ignored.
REQ-023 Reads while READY is low SHALL return 0 on all DOUT ports.
REQ-024 In RUN, WENx low SHALL write DIx to entry[WAx] on the rising edge.
REQ-025 If both ports write the same address in one cycle, port 1 data SHALL be stored.
REQ-026 A write to an address >= ENTRY SHALL be ignored, with no aliasing.
REQ-027 If ZERO_R0=1, writes to address 0 SHALL be ignored and reads of address 0 SHALL return 0.
REQ-028 Reads SHALL be combinational: DOUT[k] = entry[RA[k]], and a read of an address >= ENTRY SHALL return 0.
REQ-029 If BYPASS=1 in RUN, a read whose address matches a valid active write in the same cycle SHALL return that write data.
REQ-030 For forwarding, port 1 SHALL take precedence over port 0, and the ZERO_R0 and out-of-range rules SHALL still apply.
REQ-031 If BYPASS=0, written data SHALL appear on DOUT only after the write edge.
REQ-032 All read ports SHALL be independent; any number may read the same address.

Reset
REQ-033 During RST and CLEAR, READY SHALL be 0 and every DOUT port SHALL be 0.
REQ-034 After CLEAR completes, every entry SHALL hold 0.
REQ-035 The only reset is RST; there SHALL be no asynchronous or initial-block memory loading.

Verification
REQ-036 Init: pulse RST for 1 cycle, ENTRY=32.
- READY stays 0 for 32 cycles and is 1 on cycle 32.
- Reading all addresses then returns 0.
REQ-037 Mid-clear reset: assert RST at clear cycle 10, then release.
- READY rises exactly 32 cycles after the second release.
- A write of 0xDEAD to address 5 during CLEAR is lost; address 5 reads 0.
REQ-038 Dual write, same address: in RUN, WA0=WA1=7, DI0=0x1111, DI1=0x2222, both WEN low.
- Next cycle, address 7 reads 0x2222 on every read port.
REQ-039 Bypass: BYPASS=1, WA0=3, DI0=0xA5A5A5A5, RA port0=3 in the same cycle.
- DOUT0 = 0xA5A5A5A5 before the edge.
- With BYPASS=0, DOUT0 shows the old value until the edge.
REQ-040 Zero register: ZERO_R0=1, write 0xFFFFFFFF to address 0.
- Address 0 reads 0, both forwarded and after the edge.
- With ZERO_R0=0, address 0 reads 0xFFFFFFFF after the edge.
REQ-041 Out of range: ENTRY=24, AW=5, write 0x1234 to address 28.
- Address 28 reads 0.
- Addresses 4 and 12 are unchanged.

Source files
------------

// File: rtl/mp_regfile.sv
// mp_regfile: multi-port register file with two write ports, NRD combinational
// read ports, optional same-cycle write forwarding and optional zero entry 0.
// After reset the array is swept to zero one entry per cycle; READY marks the end
// of that sweep, and until then writes are dropped and all reads return zero.
//
// state | meaning
// ------+---------------------------------------------------------------
// CLEAR | zeroing entry[cnt] each cycle; writes ignored, reads return 0
// RUN   | normal operation; READY high
module mp_regfile #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int ENTRY   = 32,
    parameter int NRD     = 2,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WEN0,
    input  logic [AW-1:0]     WA0,
    input  logic [DW-1:0]     DI0,
    input  logic              WEN1,
    input  logic [AW-1:0]     WA1,
    input  logic [DW-1:0]     DI1,
    input  logic [NRD*AW-1:0] RA,
    output logic [NRD*DW-1:0] DOUT,
    output logic              READY
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST    = AW'(ENTRY - 1);
    localparam logic [AW:0]   ENTRY_X = (AW + 1)'(ENTRY);

    state_t          state, state_nxt;
    logic [AW-1:0]   cnt, cnt_nxt;
    logic [DW-1:0]   mem [ENTRY];
    logic            we0, we1;
    logic [NRD*DW-1:0] dout_w;

    // An address is writable/readable only if it is inside the array and,
    // when entry 0 is hardwired, not zero.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < ENTRY_X) && !((ZERO_R0 != 0) && (a == '0));
    endfunction

    assign READY = (state == RUN);
    assign we0   = READY && !WEN0 && addr_ok(WA0);
    assign we1   = READY && !WEN1 && addr_ok(WA1);
    assign DOUT  = dout_w;

    // State and sweep counter register; reset restarts the sweep from entry 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Sweep advances one entry per cycle and hands over to RUN after the last one.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Array update: zero sweep during CLEAR, port writes in RUN with port 1 last.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int e = 0; e < ENTRY; e++) begin
                if (state == CLEAR) begin
                    if (cnt == AW'(e)) mem[e] <= '0;
                end else begin
                    if (we0 && (WA0 == AW'(e))) mem[e] <= DI0;
                    if (we1 && (WA1 == AW'(e))) mem[e] <= DI1;
                end
            end
        end
    end

    // Combinational read per port, with optional forwarding of this cycle's writes.
    always_comb begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        dout_w = '0;
        ra     = '0;
        rd     = '0;
        for (int k = 0; k < NRD; k++) begin
            ra = RA[k*AW +: AW];
            rd = '0;
            if (READY) begin
                for (int e = 0; e < ENTRY; e++) begin
                    if (ra == AW'(e)) rd = mem[e];
                end
                if (!addr_ok(ra)) rd = '0;
                if (BYPASS != 0) begin
                    if (we0 && (WA0 == ra)) rd = DI0;
                    if (we1 && (WA1 == ra)) rd = DI1;
                end
            end
            dout_w[k*DW +: DW] = rd;
        end
    end

endmodule

// File: tb/tb_mp_regfile.sv
// Bench for mp_regfile: a default instance (32 entries, forwarding, zero entry 0)
// and an alternate one (24 entries, no forwarding, entry 0 writable) share stimulus.
module tb_mp_regfile;

    logic        CLK;
    logic        RST;
    logic        WEN0, WEN1;
    logic [4:0]  WA0, WA1;
    logic [31:0] DI0, DI1;
    logic [9:0]  RA;
    logic [63:0] d_dout, a_dout;
    logic        d_ready, a_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    mp_regfile #(.DW(32), .AW(5), .ENTRY(32), .NRD(2), .BYPASS(1), .ZERO_R0(1)) u_dut (
        .CLK(CLK), .RST(RST),
        .WEN0(WEN0), .WA0(WA0), .DI0(DI0),
        .WEN1(WEN1), .WA1(WA1), .DI1(DI1),
        .RA(RA), .DOUT(d_dout), .READY(d_ready)
    );

    mp_regfile #(.DW(32), .AW(5), .ENTRY(24), .NRD(2), .BYPASS(0), .ZERO_R0(0)) u_alt (
        .CLK(CLK), .RST(RST),
        .WEN0(WEN0), .WA0(WA0), .DI0(DI0),
        .WEN1(WEN1), .WA1(WA1), .DI1(DI1),
        .RA(RA), .DOUT(a_dout), .READY(a_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        wen0;
        logic [4:0]  wa0;
        logic [31:0] di0;
        logic        wen1;
        logic [4:0]  wa1;
        logic [31:0] di1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] a0;
        logic [31:0] a1;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        int n;
        // wen0 wa0 di0 | wen1 wa1 di1 | ra0 ra1 | dut d0 d1 (pre-edge) | alt d0 d1 (pre-edge)
        vt[0]  = '{1'b0, 5'd3,  32'hA5A5A5A5, 1'b1, 5'd0,  32'h0,      5'd3,  5'd3,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        32'h0};
        vt[1]  = '{1'b1, 5'd0,  32'h0,        1'b1, 5'd0,  32'h0,      5'd3,  5'd0,  32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 32'h0};
        vt[2]  = '{1'b0, 5'd7,  32'h1111,     1'b0, 5'd7,  32'h2222,   5'd7,  5'd7,  32'h2222,     32'h2222,     32'h0,        32'h0};
        vt[3]  = '{1'b1, 5'd0,  32'h0,        1'b1, 5'd0,  32'h0,      5'd7,  5'd7,  32'h2222,     32'h2222,     32'h2222,     32'h2222};
        vt[4]  = '{1'b0, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  32'h0,      5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
        vt[5]  = '{1'b1, 5'd0,  32'h0,        1'b1, 5'd0,  32'h0,      5'd0,  5'd3,  32'h0,        32'hA5A5A5A5, 32'hFFFFFFFF, 32'hA5A5A5A5};
        vt[6]  = '{1'b0, 5'd4,  32'h4444,     1'b0, 5'd12, 32'hCCCC,   5'd4,  5'd12, 32'h4444,     32'hCCCC,     32'h0,        32'h0};
        vt[7]  = '{1'b0, 5'd28, 32'h1234,     1'b1, 5'd0,  32'h0,      5'd28, 5'd4,  32'h1234,     32'h4444,     32'h0,        32'h4444};
        vt[8]  = '{1'b1, 5'd0,  32'h0,        1'b1, 5'd0,  32'h0,      5'd28, 5'd12, 32'h1234,     32'hCCCC,     32'h0,        32'hCCCC};
        vt[9]  = '{1'b0, 5'd12, 32'h9999,     1'b0, 5'd28, 32'h5678,   5'd12, 5'd28, 32'h9999,     32'h5678,     32'hCCCC,     32'h0};
        vt[10] = '{1'b1, 5'd0,  32'h0,        1'b1, 5'd0,  32'h0,      5'd12, 5'd4,  32'h9999,     32'h4444,     32'h9999,     32'h4444};
        vt[11] = '{1'b1, 5'd0,  32'h0,        1'b1, 5'd0,  32'h0,      5'd28, 5'd20, 32'h5678,     32'h0,        32'h0,        32'h0};
        vt[12] = '{1'b0, 5'd3,  32'h0,        1'b0, 5'd0,  32'h77,     5'd3,  5'd0,  32'h0,        32'h0,        32'hA5A5A5A5, 32'hFFFFFFFF};
        vt[13] = '{1'b1, 5'd0,  32'h0,        1'b1, 5'd0,  32'h0,      5'd3,  5'd0,  32'h0,        32'h0,        32'h0,        32'h77};

        RST  = 1'b1;
        WEN0 = 1'b1; WA0 = '0; DI0 = '0;
        WEN1 = 1'b1; WA1 = '0; DI1 = '0;
        RA   = {5'd5, 5'd3};
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ready_dut", {31'b0, d_ready}, 32'd0);
        chk("rst_ready_alt", {31'b0, a_ready}, 32'd0);
        chk("rst_dout_dut", d_dout[31:0], 32'd0);
        chk("rst_dout_alt", a_dout[63:32], 32'd0);

        // first clear, interrupted at cycle 10
        RST = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge CLK); #1;
            chk($sformatf("clr1_ready_dut[%0d]", i), {31'b0, d_ready}, 32'd0);
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        WEN0 = 1'b0; WA0 = 5'd5; DI0 = 32'hDEAD;
        RA = {5'd5, 5'd5};
        for (int i = 1; i <= 32; i++) begin
            @(posedge CLK); #1;
            if (i == 20) WEN0 = 1'b1;
            chk($sformatf("clr2_ready_dut[%0d]", i), {31'b0, d_ready}, (i >= 32) ? 32'd1 : 32'd0);
            chk($sformatf("clr2_ready_alt[%0d]", i), {31'b0, a_ready}, (i >= 24) ? 32'd1 : 32'd0);
            if (i < 24) chk($sformatf("clr2_dout_alt[%0d]", i), a_dout[31:0], 32'd0);
        end
        WEN0 = 1'b1;

        // every address reads zero after the sweep
        for (int a = 0; a < 32; a++) begin
            RA = {5'(31 - a), 5'(a)};
            #1;
            chk($sformatf("init_rd0_dut[%0d]", a), d_dout[31:0], 32'd0);
            chk($sformatf("init_rd1_dut[%0d]", a), d_dout[63:32], 32'd0);
            chk($sformatf("init_rd0_alt[%0d]", a), a_dout[31:0], 32'd0);
        end

        // directed vectors, checked before the edge that commits them
        for (int i = 0; i < 14; i++) begin
            WEN0 = vt[i].wen0; WA0 = vt[i].wa0; DI0 = vt[i].di0;
            WEN1 = vt[i].wen1; WA1 = vt[i].wa1; DI1 = vt[i].di1;
            RA   = {vt[i].ra1, vt[i].ra0};
            #1;
            chk($sformatf("vec%0d_dut_d0", i), d_dout[31:0],  vt[i].e0);
            chk($sformatf("vec%0d_dut_d1", i), d_dout[63:32], vt[i].e1);
            chk($sformatf("vec%0d_alt_d0", i), a_dout[31:0],  vt[i].a0);
            chk($sformatf("vec%0d_alt_d1", i), a_dout[63:32], vt[i].a1);
            @(posedge CLK); #1;
        end
        WEN0 = 1'b1; WEN1 = 1'b1;

        // reset from RUN: outputs drop, sweep repeats, contents are cleared
        RA  = {5'd7, 5'd12};
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("rerun_ready_dut", {31'b0, d_ready}, 32'd0);
        chk("rerun_ready_alt", {31'b0, a_ready}, 32'd0);
        chk("rerun_dout_dut", d_dout[31:0], 32'd0);
        chk("rerun_dout_alt", a_dout[31:0], 32'd0);
        n = 0;
        while (!d_ready && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("rerun_ready_latency", 32'(n), 32'd32);
        chk("rerun_ready_alt_after", {31'b0, a_ready}, 32'd1);
        chk("rerun_cleared_dut_12", d_dout[31:0],  32'd0);
        chk("rerun_cleared_dut_7",  d_dout[63:32], 32'd0);
        chk("rerun_cleared_alt_12", a_dout[31:0],  32'd0);
        chk("rerun_cleared_alt_7",  a_dout[63:32], 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
